// File: rtl/kme_tb_stream_pkg.sv
// Shared types and constants for the KME outbound-stream checker.
// Beat bundle, tuser codes, backpressure modes and checker states.
package kme_tb_stream_pkg;

    localparam logic [7:0] TUSER_SOT = 8'h01;
    localparam logic [7:0] TUSER_EOT = 8'h02;
    localparam logic [7:0] TUSER_MID = 8'h03;

    localparam logic [1:0] BP_ALWAYS = 2'd0;
    localparam logic [1:0] BP_ALT    = 2'd1;
    localparam logic [1:0] BP_LFSR   = 2'd2;
    localparam logic [1:0] BP_NEVER  = 2'd3;

    typedef struct packed {
        logic [63:0] tdata;
        logic [7:0]  tuser;
        logic [7:0]  tstrb;
    } kme_axis_beat_t;

    typedef enum logic {
        CHK_RUN,
        CHK_DONE
    } chk_state_e;

    // Data bytes only count where the expected strobe is set.
    function automatic logic beat_mismatch(kme_axis_beat_t e, kme_axis_beat_t d);
        logic diff;
        diff = (e.tstrb != d.tstrb) || (e.tuser != d.tuser);
        for (int i = 0; i < 8; i++) begin
            if (e.tstrb[i] && (e.tdata[8*i +: 8] != d.tdata[8*i +: 8])) begin
                diff = 1'b1;
            end
        end
        return diff;
    endfunction

    function automatic logic [31:0] sat_add(logic [31:0] a, logic [1:0] inc);
        logic [32:0] s;
        s = {1'b0, a} + {31'd0, inc};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

endpackage

// File: rtl/kme_ob_chk_fifo.sv
// Expected-beat FIFO for the outbound checker.
// Registered full/empty; full_nxt lets the owner register its own ready.
module kme_ob_chk_fifo
    import kme_tb_stream_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           push,
    input  kme_axis_beat_t din,
    input  logic           pop,
    output kme_axis_beat_t dout,
    output logic           empty,
    output logic           full_nxt
);

    localparam int AW = $clog2(DEPTH);

    kme_axis_beat_t mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic [AW:0]    count_nxt;
    logic           full;
    logic           do_push;
    logic           do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        case ({do_push, do_pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    assign full_nxt = (count_nxt == (AW+1)'(DEPTH));

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            full  <= full_nxt;
            empty <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/kme_ob_stream_checker.sv
// Outbound AXI-stream checker: compares DUT beats against pushed expectations,
// applies programmable backpressure and reports counts, first error and done/timeout.
module kme_ob_stream_checker
    import kme_tb_stream_pkg::*;
#(
    parameter int          DEPTH          = 64,
    parameter int          TIMEOUT_CYCLES = 100000,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exp_valid,
    output logic        exp_ready,
    input  logic [63:0] exp_tdata,
    input  logic [7:0]  exp_tuser,
    input  logic [7:0]  exp_tstrb,
    input  logic        exp_last,
    input  logic [1:0]  bp_mode,
    input  logic        ob_tvalid,
    output logic        ob_tready,
    input  logic [63:0] ob_tdata,
    input  logic [7:0]  ob_tuser,
    input  logic [7:0]  ob_tstrb,
    output logic        done,
    output logic        timeout,
    output logic [31:0] error_cnt,
    output logic [31:0] beat_cnt,
    output logic [31:0] frame_cnt,
    output logic        first_err_valid,
    output logic [31:0] first_err_beat
);

    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

    chk_state_e     state;
    chk_state_e     state_nxt;
    kme_axis_beat_t exp_beat;
    kme_axis_beat_t dut_beat;
    logic           fifo_empty;
    logic           fifo_full_nxt;
    logic [15:0]    lfsr;
    logic           alt;
    logic           gate;
    logic           in_frame;
    logic           last_seen;
    logic [IW-1:0]  idle_cnt;
    logic           in_run;
    logic           accept;
    logic           mismatch;
    logic           proto;
    logic           is_sot;
    logic           is_eot;
    logic           is_mid;
    logic [1:0]     err_inc;
    logic           timeout_set;

    assign in_run   = (state == CHK_RUN);
    assign done     = (state == CHK_DONE);
    assign dut_beat = '{tdata: ob_tdata, tuser: ob_tuser, tstrb: ob_tstrb};

    kme_ob_chk_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (exp_valid && exp_ready && in_run),
        .din      ('{tdata: exp_tdata, tuser: exp_tuser, tstrb: exp_tstrb}),
        .pop      (accept && in_run),
        .dout     (exp_beat),
        .empty    (fifo_empty),
        .full_nxt (fifo_full_nxt)
    );

    always_comb begin
        gate = 1'b0;
        case (bp_mode)
            BP_ALWAYS: gate = 1'b1;
            BP_ALT:    gate = alt;
            BP_LFSR:   gate = lfsr[0];
            default:   gate = 1'b0;
        endcase
    end

    // Once done, stay ready so stray DUT beats drain and get counted.
    assign ob_tready = done || (gate && !fifo_empty);
    assign accept    = ob_tvalid && ob_tready;

    assign is_sot   = (ob_tuser == TUSER_SOT);
    assign is_eot   = (ob_tuser == TUSER_EOT);
    assign is_mid   = (ob_tuser == TUSER_MID);
    assign mismatch = in_run && beat_mismatch(exp_beat, dut_beat);
    assign proto    = in_run && ((is_sot && in_frame) || ((is_mid || is_eot) && !in_frame));
    assign err_inc  = in_run ? ({1'b0, mismatch} + {1'b0, proto}) : 2'd1;

    always_comb begin
        state_nxt   = state;
        timeout_set = 1'b0;
        if (in_run) begin
            if (last_seen && fifo_empty && !accept) begin
                state_nxt = CHK_DONE;
            end else if (!fifo_empty && !accept && idle_cnt == IW'(TIMEOUT_CYCLES - 1)) begin
                state_nxt   = CHK_DONE;
                timeout_set = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= CHK_RUN;
            exp_ready       <= 1'b0;
            lfsr            <= LFSR_SEED;
            alt             <= 1'b1;
            in_frame        <= 1'b0;
            last_seen       <= 1'b0;
            idle_cnt        <= '0;
            timeout         <= 1'b0;
            error_cnt       <= '0;
            beat_cnt        <= '0;
            frame_cnt       <= '0;
            first_err_valid <= 1'b0;
            first_err_beat  <= '0;
        end else begin
            state     <= state_nxt;
            exp_ready <= (state_nxt == CHK_RUN) && !fifo_full_nxt;
            lfsr      <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
            alt       <= ~alt;
            if (exp_last)    last_seen <= 1'b1;
            if (timeout_set) timeout   <= 1'b1;
            if (accept || fifo_empty) begin
                idle_cnt <= '0;
            end else if (idle_cnt != IW'(TIMEOUT_CYCLES)) begin
                idle_cnt <= idle_cnt + 1'b1;
            end
            if (accept) begin
                beat_cnt  <= sat_add(beat_cnt, 2'd1);
                error_cnt <= sat_add(error_cnt, err_inc);
                if (in_run && is_sot) in_frame <= 1'b1;
                if (in_run && is_eot) begin
                    in_frame  <= 1'b0;
                    frame_cnt <= sat_add(frame_cnt, 2'd1);
                end
                if (!first_err_valid && err_inc != 2'd0) begin
                    first_err_valid <= 1'b1;
                    first_err_beat  <= beat_cnt;
                end
            end
        end
    end

endmodule
